// File: rtl/router_pkg.sv
// Shared definitions for the router packet generator: destination codes,
// payload limits, header packing, payload LFSR step and the generator FSM states.
package router_pkg;

  localparam logic [1:0] DEST_0       = 2'd0;
  localparam logic [1:0] DEST_1       = 2'd1;
  localparam logic [1:0] DEST_2       = 2'd2;
  localparam logic [1:0] DEST_INVALID = 2'd3;

  localparam int MAX_PAYLOAD = 63;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } gen_state_e;

  function automatic logic [7:0] pack_header(input logic [5:0] len, input logic [1:0] dest);
    return {len, dest};
  endfunction

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/router_pkt_gen_if.sv
// Byte stream link between the packet generator and the router input port.
interface router_pkt_gen_if;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       busy;

  modport master (output pkt_valid, output data_out, input busy);
  modport slave  (input pkt_valid, input data_out, output busy);
endinterface

// File: rtl/router_lfsr8.sv
// 8-bit payload LFSR; holds its value unless told to advance or reload.
module router_lfsr8
  import router_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] q
);

  // An all-zero state would lock the LFSR up.
  localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load)     q_d = SEED_NZ;
    else if (adv) q_d = lfsr8_step(q_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q_q <= SEED_NZ;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/router_pkt_gen.sv
// Packet source for router_top: header, 1-63 LFSR payload bytes, even-parity
// byte, honouring the router's busy back-pressure on every byte.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         IDLE_GAP  = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [1:0]             dest,
  input  logic [5:0]             payload_len,
  router_pkt_gen_if.master       rif,
  output logic                   done,
  output logic                   cfg_err,
  output logic                   gen_active,
  output logic [7:0]             parity_out
);

  // GAP counts down from IDLE_GAP-1 to 0, giving IDLE_GAP cycles (IDLE_GAP <= 256).
  localparam logic [7:0] GAP_INIT = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

  gen_state_e state_d, state_q;
  logic       pkt_valid_d, pkt_valid_q;
  logic [7:0] data_d, data_q;
  logic       done_d, done_q;
  logic       cfg_err_d, cfg_err_q;
  logic       gen_active_d, gen_active_q;
  logic [7:0] parity_out_d, parity_out_q;
  logic [7:0] gap_d, gap_q;
  logic [7:0] par_d, par_q;
  logic [5:0] cnt_d, cnt_q;
  logic [5:0] len_d, len_q;
  logic       lfsr_adv;
  logic [7:0] lfsr_q;
  logic       cfg_ok;

  router_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .load   (1'b0),
    .adv    (lfsr_adv),
    .q      (lfsr_q)
  );

  assign cfg_ok = (dest != DEST_INVALID) && (payload_len != 6'd0);

  always_comb begin
    state_d      = state_q;
    pkt_valid_d  = pkt_valid_q;
    data_d       = data_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    parity_out_d = parity_out_q;
    gap_d        = gap_q;
    par_d        = par_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    lfsr_adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            len_d       = payload_len;
            data_d      = pack_header(payload_len, dest);
            pkt_valid_d = 1'b1;
            state_d     = HDR;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      HDR: begin
        if (!rif.busy) begin
          par_d   = data_q;
          data_d  = lfsr_q;
          cnt_d   = 6'd0;
          state_d = PAY;
        end
      end
      PAY: begin
        // data_q always mirrors lfsr_q here, so the next byte is one LFSR step on.
        if (!rif.busy) begin
          par_d    = par_q ^ data_q;
          lfsr_adv = 1'b1;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == len_q - 6'd1) begin
            pkt_valid_d = 1'b0;
            data_d      = par_q ^ data_q;
            state_d     = PAR;
          end else begin
            data_d = lfsr8_step(lfsr_q);
          end
        end
      end
      PAR: begin
        if (!rif.busy) begin
          done_d       = 1'b1;
          parity_out_d = data_q;
          data_d       = 8'h00;
          if (IDLE_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_INIT;
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    gen_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pkt_valid_q  <= 1'b0;
      data_q       <= 8'h00;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      gen_active_q <= 1'b0;
      parity_out_q <= 8'h00;
      gap_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      pkt_valid_q  <= pkt_valid_d;
      data_q       <= data_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      gen_active_q <= gen_active_d;
      parity_out_q <= parity_out_d;
      gap_q        <= gap_d;
    end
  end

  // Running parity, byte count and latched length are only read after being loaded.
  always_ff @(posedge clk) begin
    par_q <= par_d;
    cnt_q <= cnt_d;
    len_q <= len_d;
  end

  assign rif.pkt_valid = pkt_valid_q;
  assign rif.data_out  = data_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign gen_active    = gen_active_q;
  assign parity_out    = parity_out_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen against a queue-based packet model.
module tb_router_pkt_gen;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int         GAPN = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic       done, cfg_err, gen_active;
  logic [7:0] parity_out;

  router_pkt_gen_if rif();

  router_pkt_gen #(.LFSR_SEED(SEED), .IDLE_GAP(GAPN)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .dest        (dest),
    .payload_len (payload_len),
    .rif         (rif),
    .done        (done),
    .cfg_err     (cfg_err),
    .gen_active  (gen_active),
    .parity_out  (parity_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] lfsr_m;
  logic [7:0] exp_q[$];
  logic [7:0] exp_par;
  logic [7:0] first_stream[$];

  // Observed packet.
  logic [7:0] acc_q[$];
  int         vis_q[$];
  int         pv_cycles, first_pv_c, hold_viol;
  bit         timed_out;

  function automatic logic [7:0] lfsr_next_m(input logic [7:0] s);
    // taps at stages 8,6,5,4 -> bits 7,5,4,3
    return {s[6:0], ^(s & 8'hB8)};
  endfunction

  task automatic build_exp(input logic [1:0] d, input logic [5:0] l);
    logic [7:0] p;
    exp_q.delete();
    p = {l, d};
    exp_q.push_back(p);
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(lfsr_m);
      p ^= lfsr_m;
      lfsr_m = lfsr_next_m(lfsr_m);
    end
    exp_q.push_back(p);
    exp_par = p;
  endtask

  // Issues one start and records every accepted byte until the done cycle.
  task automatic capture(input logic [1:0] d, input logic [5:0] l, input bit hold_start,
                         input bit scramble, input int stall_idx, input int stall_n,
                         input bit rand_busy, input int budget);
    int nst = 0;
    int vis = 0;
    bit in_pkt = 0, stalled = 0, par_done = 0, prev_pv = 0;
    logic [7:0] prev_d = 8'h00;
    acc_q.delete();
    vis_q.delete();
    pv_cycles = 0; first_pv_c = -1; hold_viol = 0; timed_out = 1;
    start = 1'b1; dest = d; payload_len = l;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (scramble) begin
        dest = 2'($urandom);
        payload_len = 6'($urandom);
      end
      if (!in_pkt && rif.pkt_valid) begin
        in_pkt = 1;
        first_pv_c = c;
      end
      if (stalled && (rif.data_out !== prev_d || rif.pkt_valid !== prev_pv)) hold_viol++;
      if (rif.pkt_valid) pv_cycles++;
      if (par_done) begin
        timed_out = 0;
        break;
      end
      if (in_pkt) begin
        vis++;
        if (rand_busy) stalled = ($urandom_range(0, 3) == 0);
        else           stalled = (acc_q.size() == stall_idx) && (nst < stall_n);
        if (stalled) nst++;
        rif.busy = stalled;
        if (!stalled) begin
          acc_q.push_back(rif.data_out);
          vis_q.push_back(vis);
          vis = 0;
          if (!rif.pkt_valid) par_done = 1;
        end
        prev_d = rif.data_out;
        prev_pv = rif.pkt_valid;
      end
    end
    rif.busy = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && gen_active !== 1'b0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; dest = 2'd1; payload_len = 6'd8;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      @(negedge clk);
      checks++;
      if ({rif.pkt_valid, rif.data_out, done, cfg_err, gen_active, parity_out} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h required 0",
                 {rif.pkt_valid, rif.data_out, done, cfg_err, gen_active, parity_out});
      end
    end
    start = 1'b0;
    resetn = 1'b1;
    lfsr_m = SEED;
  endtask

  task automatic test_basic();
    logic [7:0] x, got;
    wait_idle();
    build_exp(2'd1, 6'd8);
    capture(2'd1, 6'd8, 0, 0, -1, 0, 0, 200);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done required done"); end
    checks++;
    if (first_pv_c !== 0) begin errors++; $display("FAIL basic_hdr_latency: got %0d required 0", first_pv_c); end
    got = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++;
    if (got !== 8'h21) begin errors++; $display("FAIL basic_header: got %h required 21", got); end
    checks++;
    if (acc_q.size() !== 10) begin errors++; $display("FAIL basic_len: got %0d required 10", acc_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d: got %h required %h", i, got, exp_q[i]); end
    end
    checks++;
    if (pv_cycles !== 9) begin errors++; $display("FAIL basic_pv_cycles: got %0d required 9", pv_cycles); end
    x = 8'h00;
    for (int i = 0; i < 9 && i < acc_q.size(); i++) x ^= acc_q[i];
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", done); end
    checks++;
    if (parity_out !== exp_par) begin errors++; $display("FAIL basic_parity_model: got %h required %h", parity_out, exp_par); end
    checks++;
    if (parity_out !== x) begin errors++; $display("FAIL basic_parity_xor: got %h required %h", parity_out, x); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b required 0", done); end
    first_stream = acc_q;
  endtask

  task automatic test_busy();
    logic [7:0] got;
    int v;
    wait_idle();
    build_exp(2'd2, 6'd5);
    capture(2'd2, 6'd5, 0, 0, 3, 3, 0, 200);
    checks++;
    if (timed_out) begin errors++; $display("FAIL busy_timeout: got no done required done"); end
    got = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++;
    if (got !== 8'h16) begin errors++; $display("FAIL busy_header: got %h required 16", got); end
    checks++;
    if (acc_q.size() !== 7) begin errors++; $display("FAIL busy_len: got %0d required 7", acc_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL busy_byte%0d: got %h required %h", i, got, exp_q[i]); end
    end
    v = (vis_q.size() > 3) ? vis_q[3] : -1;
    checks++;
    if (v !== 4) begin errors++; $display("FAIL busy_stall_visible: got %0d required 4", v); end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL busy_hold: got %0d changes required 0", hold_viol); end
    checks++;
    if (pv_cycles !== 9) begin errors++; $display("FAIL busy_pv_cycles: got %0d required 9", pv_cycles); end
    checks++;
    if (parity_out !== exp_par) begin errors++; $display("FAIL busy_parity: got %h required %h", parity_out, exp_par); end
  endtask

  task automatic test_cfg_err();
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      dest = (k == 0) ? 2'd3 : 2'd1;
      payload_len = (k == 0) ? 6'd5 : 6'd0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({cfg_err, rif.pkt_valid, gen_active} !== 3'b100) begin
        errors++; $display("FAIL cfg_err_pulse%0d: got %b required 100", k, {cfg_err, rif.pkt_valid, gen_active});
      end
      @(negedge clk);
      checks++;
      if ({cfg_err, rif.pkt_valid, gen_active} !== 3'b000) begin
        errors++; $display("FAIL cfg_err_clear%0d: got %b required 000", k, {cfg_err, rif.pkt_valid, gen_active});
      end
    end
  endtask

  task automatic test_reset_mid();
    int pvc = 0;
    logic [7:0] got;
    wait_idle();
    start = 1'b1; dest = 2'd1; payload_len = 6'd8;
    for (int c = 0; c < 30 && pvc < 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rif.pkt_valid) pvc++;
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rif.pkt_valid, rif.data_out, done, cfg_err, gen_active, parity_out} !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h required 0",
               {rif.pkt_valid, rif.data_out, done, cfg_err, gen_active, parity_out});
    end
    @(negedge clk);
    resetn = 1'b1;
    lfsr_m = SEED;
    wait_idle();
    build_exp(2'd1, 6'd8);
    capture(2'd1, 6'd8, 0, 0, -1, 0, 0, 200);
    checks++;
    if (timed_out) begin errors++; $display("FAIL midreset_timeout: got no done required done"); end
    checks++;
    if (acc_q.size() !== first_stream.size()) begin
      errors++; $display("FAIL midreset_len: got %0d required %0d", acc_q.size(), first_stream.size());
    end
    for (int i = 0; i < first_stream.size(); i++) begin
      got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
      checks++;
      if (got !== first_stream[i]) begin errors++; $display("FAIL midreset_byte%0d: got %h required %h", i, got, first_stream[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1[$];
    logic [7:0] got;
    logic [1:0] d1, d2;
    logic [5:0] l1, l2;
    wait_idle();
    d1 = 2'($urandom_range(0, 2)); l1 = 6'($urandom_range(1, 63));
    d2 = 2'($urandom_range(0, 2)); l2 = 6'($urandom_range(1, 63));
    build_exp(d1, l1);
    e1 = exp_q;
    capture(d1, l1, 1, 1, -1, 0, 0, 300);
    checks++;
    if (timed_out) begin errors++; $display("FAIL b2b_timeout1: got no done required done"); end
    for (int i = 0; i < e1.size(); i++) begin
      got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
      checks++;
      if (got !== e1[i]) begin errors++; $display("FAIL b2b_pkt1_byte%0d: got %h required %h", i, got, e1[i]); end
    end
    build_exp(d2, l2);
    capture(d2, l2, 1, 0, -1, 0, 0, 300);
    start = 1'b0;
    checks++;
    if (first_pv_c !== GAPN) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles required %0d", first_pv_c, GAPN); end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_pkt2_len: got %0d required %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL b2b_pkt2_byte%0d: got %h required %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] got;
    logic [1:0] d;
    logic [5:0] l;
    for (int p = 0; p < 4; p++) begin
      wait_idle();
      d = 2'($urandom_range(0, 2));
      l = 6'($urandom_range(1, 63));
      build_exp(d, l);
      capture(d, l, 0, 0, -1, 0, 1, 400);
      checks++;
      if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: got no done required done", p); end
      checks++;
      if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d required %0d", p, acc_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < acc_q.size()) ? acc_q[i] : 8'hxx;
        checks++;
        if (got !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %h required %h", p, i, got, exp_q[i]); end
      end
      checks++;
      if (hold_viol !== 0) begin errors++; $display("FAIL rand%0d_hold: got %0d changes required 0", p, hold_viol); end
      checks++;
      if (parity_out !== exp_par) begin errors++; $display("FAIL rand%0d_parity: got %h required %h", p, parity_out, exp_par); end
    end
  endtask

  initial begin
    rif.busy = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_cfg_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required completion");
    $fatal(1);
  end

endmodule
